// File: rtl/periph_irq_pkg.sv
// Shared constants for the peripheral interrupt router: register word
// indices, default line count and the per-source trigger mode encoding.
package periph_irq_pkg;

   localparam int NLINES_DEFAULT = 15;

   localparam logic [7:0] IRQ_STATUS_ADDR = 8'h00;
   localparam logic [7:0] IRQ_CLEAR_ADDR  = 8'h01;
   localparam logic [7:0] IRQ_ENABLE_ADDR = 8'h02;
   localparam logic [7:0] IRQ_MODE_ADDR   = 8'h03;
   localparam logic [7:0] IRQ_RAW_ADDR    = 8'h04;
   localparam logic [7:0] IRQ_LINES_ADDR  = 8'h05;

   typedef enum logic {
      IRQ_MODE_LEVEL = 1'b0,
      IRQ_MODE_EDGE  = 1'b1
   } irq_mode_e;

endpackage

// File: rtl/irq_sync_edge.sv
// Two-flop synchroniser for one asynchronous interrupt request, plus a
// one-cycle rise pulse taken from the synchronised level.
module irq_sync_edge (
   input  logic PCLK,
   input  logic PRESETn_synch,
   input  logic irq_in,
   output logic sync_o,
   output logic rise_o
);

   logic s1_q, s1_d;
   logic s2_q, s2_d;
   logic s2_prev_q, s2_prev_d;

   always_comb begin
      s1_d      = irq_in;
      s2_d      = s1_q;
      s2_prev_d = s2_q;
   end

   always_ff @(posedge PCLK or negedge PRESETn_synch) begin
      if (!PRESETn_synch) begin
         s1_q      <= 1'b0;
         s2_q      <= 1'b0;
         s2_prev_q <= 1'b0;
      end else begin
         s1_q      <= s1_d;
         s2_q      <= s2_d;
         s2_prev_q <= s2_prev_d;
      end
   end

   assign sync_o = s2_q;
   assign rise_o = s2_q & ~s2_prev_q;

endmodule

// File: rtl/periph_irq_router.sv
// APB-programmable router: latches per-source pending bits (edge or level)
// and ORs enabled sources onto CPU lines through each source's mapping vector.
module periph_irq_router
   import periph_irq_pkg::*;
#(
   parameter int          NSRC           = 4,
   parameter int          NLINES         = NLINES_DEFAULT,
   parameter logic [31:0] DEFAULT_ENABLE = 32'd0,
   parameter logic [31:0] DEFAULT_MODE   = 32'd0
) (
   input  logic                   PCLK,
   input  logic                   PRESETn_synch,
   input  logic                   PSEL,
   input  logic                   PENABLE,
   input  logic [9:2]             PADDR,
   input  logic                   PWRITE,
   input  logic [31:0]            PWDATA,
   output logic                   PREADY,
   output logic [31:0]            PRDATA,
   input  logic [NSRC-1:0]        src_irq,
   input  logic [NSRC*NLINES-1:0] src_map,
   output logic [NLINES-1:0]      cpu_irq
);

   logic [NSRC-1:0]   s2;
   logic [NSRC-1:0]   rise;
   logic [NSRC-1:0]   pending_q, pending_d;
   logic [NSRC-1:0]   enable_q, enable_d;
   logic [NSRC-1:0]   mode_q, mode_d;
   logic [NLINES-1:0] cpu_irq_q, cpu_irq_d;
   logic              pready_q, pready_d;
   logic [31:0]       prdata_q, prdata_d;
   logic [9:2]        rd_addr_q, rd_addr_d;

   logic              wr_acc, rd_setup, rd_load;
   logic [NSRC-1:0]   clr;
   logic [31:0]       rd_val;
   logic              unused_pwdata;

   assign unused_pwdata = ^PWDATA;

   for (genvar g = 0; g < NSRC; g++) begin : g_sync
      irq_sync_edge u_sync (
         .PCLK          (PCLK),
         .PRESETn_synch (PRESETn_synch),
         .irq_in        (src_irq[g]),
         .sync_o        (s2[g]),
         .rise_o        (rise[g])
      );
   end

   always_comb begin
      wr_acc   = PSEL & PENABLE & PWRITE;
      rd_setup = PSEL & ~PENABLE & ~PWRITE;
      // Only the first access cycle (PREADY still low) loads read data.
      rd_load  = PSEL & PENABLE & ~PWRITE & ~pready_q;

      clr      = (wr_acc && PADDR == IRQ_CLEAR_ADDR) ? PWDATA[NSRC-1:0] : '0;
      enable_d = (wr_acc && PADDR == IRQ_ENABLE_ADDR) ? PWDATA[NSRC-1:0] : enable_q;
      mode_d   = (wr_acc && PADDR == IRQ_MODE_ADDR) ? PWDATA[NSRC-1:0] : mode_q;

      // A rise in the same cycle as a clear keeps the source pending.
      pending_d = '0;
      for (int i = 0; i < NSRC; i++) begin
         if (mode_q[i] == IRQ_MODE_EDGE)
            pending_d[i] = rise[i] | (pending_q[i] & ~clr[i]);
         else
            pending_d[i] = s2[i];
      end

      cpu_irq_d = '0;
      for (int i = 0; i < NSRC; i++) begin
         if (pending_q[i] && enable_q[i])
            cpu_irq_d = cpu_irq_d | src_map[i*NLINES +: NLINES];
      end

      rd_val = '0;
      case (rd_addr_q)
         IRQ_STATUS_ADDR: rd_val[NSRC-1:0]   = pending_q;
         IRQ_ENABLE_ADDR: rd_val[NSRC-1:0]   = enable_q;
         IRQ_MODE_ADDR:   rd_val[NSRC-1:0]   = mode_q;
         IRQ_RAW_ADDR:    rd_val[NSRC-1:0]   = s2;
         IRQ_LINES_ADDR:  rd_val[NLINES-1:0] = cpu_irq_q;
         default:         rd_val             = '0;
      endcase

      pready_d  = 1'b1;
      prdata_d  = '0;
      rd_addr_d = rd_addr_q;
      if (rd_setup) begin
         pready_d  = 1'b0;
         rd_addr_d = PADDR;
      end else if (rd_load) begin
         prdata_d = rd_val;
      end
   end

   always_ff @(posedge PCLK or negedge PRESETn_synch) begin
      if (!PRESETn_synch) begin
         pending_q <= '0;
         enable_q  <= DEFAULT_ENABLE[NSRC-1:0];
         mode_q    <= DEFAULT_MODE[NSRC-1:0];
         cpu_irq_q <= '0;
         pready_q  <= 1'b1;
         prdata_q  <= '0;
         rd_addr_q <= '0;
      end else begin
         pending_q <= pending_d;
         enable_q  <= enable_d;
         mode_q    <= mode_d;
         cpu_irq_q <= cpu_irq_d;
         pready_q  <= pready_d;
         prdata_q  <= prdata_d;
         rd_addr_q <= rd_addr_d;
      end
   end

   assign PREADY  = pready_q;
   assign PRDATA  = prdata_q;
   assign cpu_irq = cpu_irq_q;

endmodule

// File: tb/tb_periph_irq_router.sv
// Directed bench for periph_irq_router: a cycle model of the documented
// behaviour is compared every cycle, plus hand-computed literal checks.
module tb_periph_irq_router;

   localparam int NSRC   = 4;
   localparam int NLINES = 15;

   logic                   PCLK = 1'b0;
   logic                   PRESETn_synch = 1'b1;
   logic                   PSEL = 1'b0;
   logic                   PENABLE = 1'b0;
   logic [7:0]             PADDR = '0;
   logic                   PWRITE = 1'b0;
   logic [31:0]            PWDATA = '0;
   logic                   PREADY;
   logic [31:0]            PRDATA;
   logic [NSRC-1:0]        src_irq = '0;
   logic [NSRC*NLINES-1:0] src_map = '0;
   logic [NLINES-1:0]      cpu_irq;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   periph_irq_router #(
      .NSRC(NSRC), .NLINES(NLINES), .DEFAULT_ENABLE(32'd0), .DEFAULT_MODE(32'd0)
   ) dut (
      .PCLK(PCLK), .PRESETn_synch(PRESETn_synch), .PSEL(PSEL), .PENABLE(PENABLE),
      .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA), .PREADY(PREADY),
      .PRDATA(PRDATA), .src_irq(src_irq), .src_map(src_map), .cpu_irq(cpu_irq)
   );

   always #5 PCLK = ~PCLK;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [NSRC-1:0]   m_pend, m_en, m_mode;
   logic [NSRC-1:0]   hist [3];   // src_irq samples at the last three edges
   logic [NLINES-1:0] m_cpu;
   logic              m_pready;
   logic [31:0]       m_prdata;
   logic [7:0]        m_addr;

   function automatic logic [31:0] m_reg(input logic [7:0] a, input logic [NSRC-1:0] raw);
      case (a)
         8'h00:   return 32'(m_pend);
         8'h02:   return 32'(m_en);
         8'h03:   return 32'(m_mode);
         8'h04:   return 32'(raw);
         8'h05:   return 32'(m_cpu);
         default: return 32'd0;
      endcase
   endfunction

   always @(posedge PCLK or negedge PRESETn_synch) begin
      logic [NSRC-1:0]   raw, rise, clr, pend_n;
      logic [NLINES-1:0] cpu_n;
      logic              wr;
      if (!PRESETn_synch) begin
         m_pend <= '0; m_en <= '0; m_mode <= '0; m_cpu <= '0;
         m_pready <= 1'b1; m_prdata <= '0; m_addr <= '0;
         hist[0] <= '0; hist[1] <= '0; hist[2] <= '0;
      end else begin
         raw  = hist[1];
         rise = hist[1] & ~hist[2];
         wr   = PSEL && PENABLE && PWRITE;
         clr  = (wr && PADDR == 8'h01) ? PWDATA[NSRC-1:0] : '0;
         for (int i = 0; i < NSRC; i++)
            pend_n[i] = m_mode[i] ? (rise[i] || (m_pend[i] && !clr[i])) : raw[i];
         cpu_n = '0;
         for (int i = 0; i < NSRC; i++)
            if (m_pend[i] && m_en[i]) cpu_n = cpu_n | src_map[i*NLINES +: NLINES];
         if (PSEL && !PENABLE && !PWRITE) begin
            m_pready <= 1'b0; m_prdata <= '0; m_addr <= PADDR;
         end else if (PSEL && PENABLE && !PWRITE && !m_pready) begin
            m_pready <= 1'b1; m_prdata <= m_reg(m_addr, raw);
         end else begin
            m_pready <= 1'b1; m_prdata <= '0;
         end
         if (wr && PADDR == 8'h02) m_en <= PWDATA[NSRC-1:0];
         if (wr && PADDR == 8'h03) m_mode <= PWDATA[NSRC-1:0];
         m_pend <= pend_n;
         m_cpu  <= cpu_n;
         hist[2] <= hist[1]; hist[1] <= hist[0]; hist[0] <= src_irq;
      end
   end

   always @(negedge PCLK) begin
      if (chk_en) begin
         check("model_pready", 32'(PREADY), 32'(m_pready));
         check("model_prdata", PRDATA, m_prdata);
         check("model_cpu_irq", 32'(cpu_irq), 32'(m_cpu));
      end
   end

   // ---------------- driver tasks ----------------
   task automatic apb_write(input logic [7:0] addr, input logic [31:0] data);
      @(negedge PCLK);
      PSEL = 1'b1; PWRITE = 1'b1; PENABLE = 1'b0; PADDR = addr; PWDATA = data;
      @(negedge PCLK);
      PENABLE = 1'b1;
      @(negedge PCLK);
      PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
   endtask

   task automatic apb_read(input logic [7:0] addr, output logic [31:0] data, output int waits);
      @(negedge PCLK);
      PSEL = 1'b1; PWRITE = 1'b0; PENABLE = 1'b0; PADDR = addr;
      @(negedge PCLK);
      PENABLE = 1'b1;
      waits = 0;
      for (int k = 0; k < 16 && !PREADY; k++) begin
         waits++;
         @(negedge PCLK);
      end
      if (!PREADY) begin
         errors++;
         $display("FAIL read_timeout: PREADY still %b, required 1", PREADY);
      end
      data = PRDATA;
      @(negedge PCLK);
      PSEL = 1'b0; PENABLE = 1'b0;
   endtask

   task automatic read_check(input string name, input logic [7:0] addr, input logic [31:0] exp);
      logic [31:0] d;
      int w;
      apb_read(addr, d, w);
      check(name, d, exp);
      check({name, "_waits"}, 32'(w), 32'd1);
   endtask

   // ---------------- directed stimulus ----------------
   initial begin
      int lat;
      #2 PRESETn_synch = 1'b0;
      repeat (2) @(negedge PCLK);
      PRESETn_synch = 1'b1;
      chk_en = 1'b1;
      check("reset_pready", 32'(PREADY), 32'd1);
      check("reset_cpu_irq", 32'(cpu_irq), 32'd0);

      read_check("rst_status", 8'h00, 32'd0);
      read_check("rst_enable", 8'h02, 32'd0);
      read_check("rst_mode",   8'h03, 32'd0);
      read_check("rst_lines",  8'h05, 32'd0);

      // Edge mode, source 0 on line 3
      src_map[0 +: NLINES] = 15'h0008;
      apb_write(8'h03, 32'h1);
      apb_write(8'h02, 32'h1);
      @(negedge PCLK);
      src_irq[0] = 1'b1;
      lat = 0;
      for (int n = 1; n <= 8; n++) begin
         @(negedge PCLK);
         if (n == 1) src_irq[0] = 1'b0;
         if (lat == 0 && cpu_irq == 15'h0008) lat = n;
      end
      check("edge_latency", 32'(lat), 32'd4);
      read_check("edge_status", 8'h00, 32'd1);
      apb_write(8'h01, 32'h1);
      check("edge_clr_hold", 32'(cpu_irq), 32'h0008);
      @(negedge PCLK);
      check("edge_clr_done", 32'(cpu_irq), 32'h0000);

      // Level mode fan-out; CLEAR ignored
      apb_write(8'h03, 32'h0);
      src_map[0 +: NLINES] = 15'h4001;
      src_irq[0] = 1'b1;
      repeat (6) @(negedge PCLK);
      check("level_fanout", 32'(cpu_irq), 32'h4001);
      apb_write(8'h01, 32'h1);
      repeat (2) @(negedge PCLK);
      check("level_clr_ignored", 32'(cpu_irq), 32'h4001);
      read_check("level_status", 8'h00, 32'd1);
      src_irq[0] = 1'b0;
      repeat (6) @(negedge PCLK);
      check("level_drop", 32'(cpu_irq), 32'h0000);

      // Set/clear collision in edge mode
      apb_write(8'h03, 32'h1);
      @(negedge PCLK);
      src_irq[0] = 1'b1;
      apb_write(8'h01, 32'h1);
      read_check("collision_status", 8'h00, 32'd1);

      // Multi-source OR and masking
      src_map[1*NLINES +: NLINES] = 15'h0002;
      src_map[2*NLINES +: NLINES] = 15'h0006;
      src_irq[1] = 1'b1;
      src_irq[2] = 1'b1;
      apb_write(8'h02, 32'h6);
      repeat (5) @(negedge PCLK);
      check("multi_or", 32'(cpu_irq), 32'h0006);
      apb_write(8'h02, 32'h2);
      check("mask_before", 32'(cpu_irq), 32'h0006);
      @(negedge PCLK);
      check("mask_after", 32'(cpu_irq), 32'h0002);

      // Zero-mapped source still latches pending
      src_irq[3] = 1'b1;
      repeat (4) @(negedge PCLK);
      read_check("all_status", 8'h00, 32'hF);
      read_check("lines_reg", 8'h05, 32'h0002);
      read_check("raw_reg", 8'h04, 32'hF);
      read_check("unused_addr", 8'h07, 32'h0);

      // Asynchronous reset during a RAW read
      @(negedge PCLK);
      PSEL = 1'b1; PWRITE = 1'b0; PENABLE = 1'b0; PADDR = 8'h04;
      @(posedge PCLK);
      #1 check("midread_wait", 32'(PREADY), 32'd0);
      #1 PRESETn_synch = 1'b0;
      PSEL = 1'b0;
      #1;
      check("midread_rst_pready", 32'(PREADY), 32'd1);
      check("midread_rst_prdata", PRDATA, 32'd0);
      check("midread_rst_cpu", 32'(cpu_irq), 32'd0);
      repeat (2) @(negedge PCLK);
      PRESETn_synch = 1'b1;
      read_check("post_rst_enable", 8'h02, 32'd0);
      read_check("post_rst_mode", 8'h03, 32'd0);

      repeat (3) @(negedge PCLK);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      errors++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
